// File: rtl/ps2_pkg.sv
// ps2_pkg: shared scan-code constants, key indices and frame-state type
// for the PS/2 direction-key decoder.
package ps2_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  // Extended (E0-prefixed) arrow codes
  localparam logic [7:0] SC_AR_UP    = 8'h75;
  localparam logic [7:0] SC_AR_LEFT  = 8'h6B;
  localparam logic [7:0] SC_AR_DOWN  = 8'h72;
  localparam logic [7:0] SC_AR_RIGHT = 8'h74;

  // Plain WASD and space codes
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;

  // Bit positions inside the 4-bit held-direction vectors
  localparam int KEY_UP    = 0;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_RIGHT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronizes the PS/2 lines, glitch-filters the clock,
// and frames start/8 data/parity/stop bits into bytes. A mid-frame stall
// longer than TIMEOUT_CYCLES aborts the frame.
// Optional macro PS2_PARITY_CHECK_EN: also reject frames with bad odd parity.
// o_byte_valid / o_err / o_abort are single-cycle strobes in the cycle of
// the stop-bit (or timeout) event, so the consumer's registers land one
// Clk later.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_Clk,
  input  logic       PS2_Data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_err,
  output logic       o_abort
);

  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             r_clk_s1, r_clk_s2;
  logic             r_dat_s1, r_dat_s2;
  logic             r_filt_clk;
  logic [FLT_W-1:0] r_filt_cnt;
  logic             w_filt_flip;
  logic             w_fall;

  frame_state_t     r_state, w_state_nxt;
  logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_parity, w_parity_nxt;
  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic             w_valid, w_err, w_abort;
  logic             w_par_ok;

  // Two-flop synchronizers; lines idle high
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= PS2_Clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= PS2_Data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Filtered level flips only after FILTER_LEN consecutive differing samples
  assign w_filt_flip = (r_clk_s2 != r_filt_clk) && (r_filt_cnt == FLT_W'(FILTER_LEN - 1));
  assign w_fall      = w_filt_flip && r_filt_clk;

  // Glitch filter on the synchronized clock
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_clk_s2 == r_filt_clk) begin
      r_filt_cnt <= '0;
    end else if (w_filt_flip) begin
      r_filt_clk <= r_clk_s2;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + FLT_W'(1);
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign w_par_ok = odd_parity_ok(r_shift, r_parity);
`else
  assign w_par_ok = 1'b1;
`endif

  // Frame FSM next-state, shift register and timeout logic
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_tmo_cnt_nxt = r_tmo_cnt;
    w_valid       = 1'b0;
    w_err         = 1'b0;
    w_abort       = 1'b0;
    if (w_fall) begin
      w_tmo_cnt_nxt = '0;
      case (r_state)
        IDLE: begin
          if (!r_dat_s2) begin
            w_state_nxt   = DATA;
            w_bit_cnt_nxt = 3'd0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        DATA: begin
          w_shift_nxt   = {r_dat_s2, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = PARITY;
          end else begin
            w_state_nxt = DATA;
          end
        end
        PARITY: begin
          w_parity_nxt = r_dat_s2;
          w_state_nxt  = STOP;
        end
        STOP: begin
          w_state_nxt = IDLE;
          if (r_dat_s2 && w_par_ok) begin
            w_valid = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (r_state != IDLE) begin
      if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        w_state_nxt   = IDLE;
        w_tmo_cnt_nxt = '0;
        w_err         = 1'b1;
        w_abort       = 1'b1;
      end else begin
        w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
      end
    end else begin
      w_tmo_cnt_nxt = '0;
    end
  end

  // Frame FSM state and datapath registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_parity  <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
      r_tmo_cnt <= w_tmo_cnt_nxt;
    end
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = w_valid;
  assign o_err        = w_err;
  assign o_abort      = w_abort;

endmodule

// File: rtl/ps2_dir_keys.sv
// ps2_dir_keys: decodes PS/2 make/break scan codes into held-key levels
// for up/left/down/right (arrow keys or WASD) and launch (space).
// Optional macro PS2_PARITY_CHECK_EN: frames with bad parity are rejected.
module ps2_dir_keys
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_Clk,
  input  logic       PS2_Data,
  output logic       up,
  output logic       left,
  output logic       down,
  output logic       right,
  output logic       launch,
  output logic [7:0] keycode,
  output logic       newKey,
  output logic       frameErr
);

  logic [7:0] w_byte;
  logic       w_byte_valid, w_err, w_abort;

  logic [3:0] r_arrow, w_arrow_nxt;
  logic [3:0] r_wasd,  w_wasd_nxt;
  logic       r_launch, w_launch_nxt;
  logic       r_ext, w_ext_nxt;
  logic       r_brk, w_brk_nxt;
  logic [7:0] r_keycode, w_keycode_nxt;
  logic       r_new_key, w_new_key_nxt;
  logic       r_frame_err;
  logic [3:0] r_dir;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .Clk          (Clk),
    .Reset        (Reset),
    .PS2_Clk      (PS2_Clk),
    .PS2_Data     (PS2_Data),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_err        (w_err),
    .o_abort      (w_abort)
  );

  // Prefix tracking and scan-code decode into held-key next state
  always_comb begin
    w_arrow_nxt   = r_arrow;
    w_wasd_nxt    = r_wasd;
    w_launch_nxt  = r_launch;
    w_ext_nxt     = r_ext;
    w_brk_nxt     = r_brk;
    w_keycode_nxt = r_keycode;
    w_new_key_nxt = 1'b0;
    if (w_byte_valid) begin
      case (w_byte)
        SC_EXT: w_ext_nxt = 1'b1;
        SC_BRK: w_brk_nxt = 1'b1;
        default: begin
          w_keycode_nxt = w_byte;
          w_new_key_nxt = 1'b1;
          w_ext_nxt     = 1'b0;
          w_brk_nxt     = 1'b0;
          if (r_ext) begin
            case (w_byte)
              SC_AR_UP:    w_arrow_nxt[KEY_UP]    = ~r_brk;
              SC_AR_LEFT:  w_arrow_nxt[KEY_LEFT]  = ~r_brk;
              SC_AR_DOWN:  w_arrow_nxt[KEY_DOWN]  = ~r_brk;
              SC_AR_RIGHT: w_arrow_nxt[KEY_RIGHT] = ~r_brk;
              default:     w_arrow_nxt = r_arrow;
            endcase
          end else begin
            case (w_byte)
              SC_W:     w_wasd_nxt[KEY_UP]    = ~r_brk;
              SC_A:     w_wasd_nxt[KEY_LEFT]  = ~r_brk;
              SC_S:     w_wasd_nxt[KEY_DOWN]  = ~r_brk;
              SC_D:     w_wasd_nxt[KEY_RIGHT] = ~r_brk;
              SC_SPACE: w_launch_nxt          = ~r_brk;
              default:  w_wasd_nxt = r_wasd;
            endcase
          end
        end
      endcase
    end else if (w_abort) begin
      w_ext_nxt = 1'b0;
      w_brk_nxt = 1'b0;
    end else begin
      w_ext_nxt = r_ext;
    end
  end

  // Held-key, prefix and output registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_arrow     <= 4'h0;
      r_wasd      <= 4'h0;
      r_launch    <= 1'b0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_keycode   <= 8'h00;
      r_new_key   <= 1'b0;
      r_frame_err <= 1'b0;
      r_dir       <= 4'h0;
    end else begin
      r_arrow     <= w_arrow_nxt;
      r_wasd      <= w_wasd_nxt;
      r_launch    <= w_launch_nxt;
      r_ext       <= w_ext_nxt;
      r_brk       <= w_brk_nxt;
      r_keycode   <= w_keycode_nxt;
      r_new_key   <= w_new_key_nxt;
      r_frame_err <= w_err;
      r_dir       <= w_arrow_nxt | w_wasd_nxt;
    end
  end

  assign up       = r_dir[KEY_UP];
  assign left     = r_dir[KEY_LEFT];
  assign down     = r_dir[KEY_DOWN];
  assign right    = r_dir[KEY_RIGHT];
  assign launch   = r_launch;
  assign keycode  = r_keycode;
  assign newKey   = r_new_key;
  assign frameErr = r_frame_err;

endmodule

// File: tb/tb_ps2_dir_keys.sv
// Directed self-checking bench for ps2_dir_keys.
module tb_ps2_dir_keys;
  import ps2_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       PS2_Clk;
  logic       PS2_Data;
  logic       up, left, down, right, launch;
  logic [7:0] keycode;
  logic       newKey, frameErr;

  int tests = 0;
  int fails = 0;
  int nk_cnt = 0;
  int err_cnt = 0;
  logic [7:0] kc_at_nk = 8'h00;
  logic [4:0] flags_at_nk = 5'h00;

  ps2_dir_keys dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .PS2_Clk  (PS2_Clk),
    .PS2_Data (PS2_Data),
    .up       (up),
    .left     (left),
    .down     (down),
    .right    (right),
    .launch   (launch),
    .keycode  (keycode),
    .newKey   (newKey),
    .frameErr (frameErr)
  );

  always #10 Clk = ~Clk;

  // Pulse monitor sampled away from the active edge
  always @(negedge Clk) begin
    if (newKey) begin
      nk_cnt      <= nk_cnt + 1;
      kc_at_nk    <= keycode;
      flags_at_nk <= {up, left, down, right, launch};
    end
    if (frameErr) err_cnt <= err_cnt + 1;
  end

  task automatic wait_clk(input int n);
    for (int i = 0; i < n; i++) @(posedge Clk);
  endtask

  task automatic send_bit(input logic b);
    PS2_Data = b;
    wait_clk(10);
    PS2_Clk = 1'b0;
    wait_clk(20);
    PS2_Clk = 1'b1;
    wait_clk(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic good_par, input logic stop);
    logic par;
    par = good_par ? ~^b : ^b;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stop);
    PS2_Data = 1'b1;
    wait_clk(5);
    #1;
  endtask

  task automatic send_ok(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b1);
  endtask

  task automatic test_reset;
    tests++;
    if ({up, left, down, right, launch, keycode, newKey, frameErr} !== 14'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h exp 0", {up, left, down, right, launch, keycode, newKey, frameErr});
    end
    tests++;
    if (dut.u_rx.r_state !== IDLE) begin
      fails++;
      $display("FAIL reset_state: got %0d exp %0d", dut.u_rx.r_state, IDLE);
    end
  endtask

  task automatic test_make_break_up;
    int nk0;
    nk0 = nk_cnt;
    send_ok(8'h1D);
    tests++;
    if (nk_cnt - nk0 !== 1) begin fails++; $display("FAIL up_make_newkey: got %0d exp 1", nk_cnt - nk0); end
    tests++;
    if (kc_at_nk !== 8'h1D || flags_at_nk !== 5'b10000) begin
      fails++; $display("FAIL up_make_at_pulse: got kc=%h flags=%b exp kc=1d flags=10000", kc_at_nk, flags_at_nk);
    end
    send_ok(8'h1D);
    tests++;
    if (up !== 1'b1) begin fails++; $display("FAIL up_typematic: got %b exp 1", up); end
    nk0 = nk_cnt;
    send_ok(8'hF0);
    tests++;
    if (up !== 1'b1 || nk_cnt !== nk0) begin
      fails++; $display("FAIL f0_prefix: got up=%b nk=%0d exp up=1 nk=0", up, nk_cnt - nk0);
    end
    send_ok(8'h1D);
    tests++;
    if ({up, left, down, right, launch} !== 5'b0 || keycode !== 8'h1D) begin
      fails++; $display("FAIL up_break: got flags=%b kc=%h exp 00000 1d", {up, left, down, right, launch}, keycode);
    end
  endtask

  task automatic test_ext_right;
    int nk0;
    nk0 = nk_cnt;
    send_ok(8'hE0);
    send_ok(8'h74);
    tests++;
    if (right !== 1'b1 || keycode !== 8'h74 || nk_cnt - nk0 !== 1) begin
      fails++; $display("FAIL ext_right_make: got r=%b kc=%h nk=%0d exp 1 74 1", right, keycode, nk_cnt - nk0);
    end
    send_ok(8'h23);
    send_ok(8'hE0);
    send_ok(8'hF0);
    send_ok(8'h74);
    tests++;
    if (right !== 1'b1 || keycode !== 8'h74) begin
      fails++; $display("FAIL right_held_by_d: got r=%b kc=%h exp 1 74", right, keycode);
    end
    send_ok(8'hF0);
    send_ok(8'h23);
    tests++;
    if ({up, left, down, right, launch} !== 5'b0) begin
      fails++; $display("FAIL right_release: got %b exp 00000", {up, left, down, right, launch});
    end
    send_ok(8'h74);
    tests++;
    if (right !== 1'b0 || keycode !== 8'h74) begin
      fails++; $display("FAIL plain_74_unmapped: got r=%b kc=%h exp 0 74", right, keycode);
    end
  endtask

  task automatic test_stop_err;
    int nk0, e0;
    nk0 = nk_cnt;
    e0 = err_cnt;
    send_frame(8'h29, 1'b1, 1'b0);
    tests++;
    if (err_cnt - e0 !== 1 || launch !== 1'b0 || nk_cnt !== nk0) begin
      fails++; $display("FAIL bad_stop: got err=%0d launch=%b nk=%0d exp 1 0 0", err_cnt - e0, launch, nk_cnt - nk0);
    end
    send_ok(8'h29);
    tests++;
    if (launch !== 1'b1 || keycode !== 8'h29) begin
      fails++; $display("FAIL launch_make: got %b kc=%h exp 1 29", launch, keycode);
    end
    send_ok(8'hF0);
    send_ok(8'h29);
    tests++;
    if (launch !== 1'b0) begin fails++; $display("FAIL launch_break: got %b exp 0", launch); end
  endtask

  task automatic test_timeout;
    int e0;
    send_ok(8'hF0);
    e0 = err_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    PS2_Data = 1'b1;
    wait_clk(50100);
    #1;
    tests++;
    if (err_cnt - e0 !== 1) begin fails++; $display("FAIL timeout_err: got %0d exp 1", err_cnt - e0); end
    tests++;
    if (dut.u_rx.r_state !== IDLE) begin
      fails++; $display("FAIL timeout_idle: got %0d exp %0d", dut.u_rx.r_state, IDLE);
    end
    send_ok(8'h1C);
    tests++;
    if (left !== 1'b1 || keycode !== 8'h1C) begin
      fails++; $display("FAIL after_timeout_left: got %b kc=%h exp 1 1c", left, keycode);
    end
  endtask

  task automatic test_parity;
    int e0;
    e0 = err_cnt;
    send_frame(8'h1B, 1'b0, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    tests++;
    if (down !== 1'b0 || err_cnt - e0 !== 1) begin
      fails++; $display("FAIL parity_reject: got down=%b err=%0d exp 0 1", down, err_cnt - e0);
    end
`else
    tests++;
    if (down !== 1'b1 || err_cnt - e0 !== 0) begin
      fails++; $display("FAIL parity_ignored: got down=%b err=%0d exp 1 0", down, err_cnt - e0);
    end
`endif
    send_ok(8'hF0);
    send_ok(8'h1B);
    tests++;
    if (down !== 1'b0 || left !== 1'b1) begin
      fails++; $display("FAIL down_break: got down=%b left=%b exp 0 1", down, left);
    end
  endtask

  task automatic test_glitch;
    int nk0, e0;
    nk0 = nk_cnt;
    e0 = err_cnt;
    PS2_Data = 1'b0;
    for (int i = 0; i < 6; i++) begin
      PS2_Clk = 1'b0;
      wait_clk(2);
      PS2_Clk = 1'b1;
      wait_clk(15);
    end
    PS2_Data = 1'b1;
    wait_clk(5);
    #1;
    tests++;
    if ({up, left, down, right, launch} !== 5'b01000 || nk_cnt !== nk0 || err_cnt !== e0 || dut.u_rx.r_state !== IDLE) begin
      fails++; $display("FAIL glitch_ignored: got flags=%b nk=%0d err=%0d st=%0d exp 01000 0 0 0",
                        {up, left, down, right, launch}, nk_cnt - nk0, err_cnt - e0, dut.u_rx.r_state);
    end
    send_ok(8'h6B);
    tests++;
    if (left !== 1'b1 || keycode !== 8'h6B || nk_cnt - nk0 !== 1) begin
      fails++; $display("FAIL post_glitch_frame: got left=%b kc=%h nk=%0d exp 1 6b 1", left, keycode, nk_cnt - nk0);
    end
  endtask

  task automatic test_reset_mid;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #3;
    Reset = 1'b1;
    #1;
    tests++;
    if ({up, left, down, right, launch, keycode, newKey, frameErr} !== 14'h0) begin
      fails++; $display("FAIL reset_mid: got %h exp 0", {up, left, down, right, launch, keycode, newKey, frameErr});
    end
    PS2_Data = 1'b1;
    wait_clk(3);
    Reset = 1'b0;
    wait_clk(3);
    send_ok(8'h1D);
    tests++;
    if ({up, left, down, right, launch} !== 5'b10000 || keycode !== 8'h1D) begin
      fails++; $display("FAIL after_reset_frame: got %b kc=%h exp 10000 1d", {up, left, down, right, launch}, keycode);
    end
  endtask

  initial begin
    Reset    = 1'b1;
    PS2_Clk  = 1'b1;
    PS2_Data = 1'b1;
    wait_clk(4);
    #1;
    test_reset;
    Reset = 1'b0;
    wait_clk(4);
    test_make_break_up;
    test_ext_right;
    test_stop_err;
    test_timeout;
    test_parity;
    test_glitch;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_dir_keys.md
Name: ps2_dir_keys

Overview:
- Receives PS/2 keyboard frames and decodes make/break scan codes into level "key held" flags: up, left, down, right and launch (space).
- Drives the direction inputs of the paddle and game-control logic, so those consumers see clean held-key levels instead of serial traffic.
- Arrow keys (E0-prefixed) and WASD map to the same flags.
- Runs entirely in the system clock domain; the PS/2 lines are treated as asynchronous inputs.

Parameters:
- FILTER_LEN, 8: consecutive equal synchronized PS2_Clk samples required before the filtered clock level changes.
- TIMEOUT_CYCLES, 50000: Clk cycles with no filtered falling edge mid-frame before the partial frame is aborted (1 ms at 50 MHz).

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  asynchronous, active-high reset.
- PS2_Clk  in  1  raw keyboard clock, asynchronous.
- PS2_Data  in  1  raw keyboard data, asynchronous.
- up, left, down, right  out  1 each  key held (arrow OR WASD).
- launch  out  1  space bar held.
- keycode  out  8  last non-prefix scan byte received.
- newKey  out  1  one-cycle pulse when keycode updates.
- frameErr  out  1  one-cycle pulse on bad stop bit, bad parity (feature on) or timeout.

Behaviour:
- Reset: all outputs 0, frame FSM in IDLE, ext and brk flags 0, filter state high (idle line). Reset asserted mid-frame discards the partial frame.
- Synchronization: 2-FF sync on both PS/2 lines, then a FILTER_LEN-sample glitch filter on the clock. A falling edge of the filtered clock is the sample strobe; data is sampled from the synchronized data line on that strobe.
- Frame FSM states: IDLE -> DATA -> PARITY -> STOP.
  - IDLE: on a strobe with data=0 (start bit) go to DATA with bit count 0. A strobe with data=1 is ignored; stay in IDLE.
  - DATA: 8 strobes; bits shift in LSB first. After the 8th, go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: on a strobe with data=1, deliver the byte and return to IDLE. With data=0, pulse frameErr, discard the byte, return to IDLE.
- Timeout: the counter resets on every strobe and runs only outside IDLE. At TIMEOUT_CYCLES it aborts to IDLE, pulses frameErr, and clears ext and brk.
- Byte delivery: decode occurs in the Clk cycle after the STOP strobe. newKey, keycode and flag updates all occur in that same cycle, i.e. 1-cycle latency from the stop-bit strobe.
- Decode rules:
  - 0xE0 sets ext. 0xF0 sets brk. Neither updates keycode or newKey.
  - Any other byte writes keycode, pulses newKey, applies held = ~brk to the matching key, then clears ext and brk.
  - Extended mapping (ext=1): 75 up, 6B left, 72 down, 74 right.
  - Non-extended mapping: 1D up (W), 1C left (A), 1B down (S), 23 right (D), 29 launch.
  - Unmapped codes (including FA, AA, and non-E0 arrow codes) change no flag.
- Output flags: each direction output is the OR of its arrow held bit and its WASD held bit. Break on one source leaves the other source's held bit intact.
- Simultaneous holds: multiple flags may be 1 at once. No arbitration here; the consumer resolves conflicts.
- Repeated bytes: a repeated make (typematic) keeps the flag at 1. A break for a key not held keeps it at 0.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: in STOP, odd parity over data+parity is also required. On failure, pulse frameErr, discard the byte, leave ext, brk and all flags unchanged.
- Undefined: the parity bit is captured and ignored; only the stop bit is checked.

Decomposition:
- Package ps2_pkg: scan-code constants (E0, F0, arrow codes, WASD codes, space) and the frame-state enum typedef {IDLE, DATA, PARITY, STOP}.
- Sub-module ps2_rx_frame: sync, filter, frame FSM and timeout. Outputs byte[7:0], byteValid pulse and err pulse.
- Top ps2_dir_keys: prefix/decode logic and held-key registers.

Test Plan:
- Frame 0x1D, then frames F0 1D -> up=1 one Clk after first stop strobe with keycode=1D and newKey pulse; up=0 after 1D stop, other flags 0.
- Frames E0 74 -> right=1, keycode=74, exactly one newKey pulse; then frames 23 and E0 F0 74 -> right stays 1 (D still held); then frames F0 23 -> right=0.
- Frame 0x29 with stop bit 0 -> frameErr pulse, launch stays 0, no newKey; next valid 0x29 -> launch=1.
- Start bit plus 3 data bits, then clock idle 50000 cycles -> frameErr pulse, FSM IDLE; next full frame 0x1C decodes correctly (left=1).
- With PS2_PARITY_CHECK_EN: frame 0x1B with even parity -> frameErr, down=0. Without the macro: same frame -> down=1.
- 2-cycle low glitches on PS2_Clk between frames -> no strobe, no output change. Reset asserted mid-frame after left=1 -> all outputs 0 immediately.
